// File: rtl/vector_store_unit.sv
// vector_store_unit: serialises one VLEN-element vector onto a valid/ready write port (rev 1.0).
// Optional VSTORE_MASK_EN adds a per-element write mask latched with start.
`default_nettype none

module vector_store_unit #(
  parameter  int VLEN   = 8,
  parameter  int EWIDTH = 32,
  parameter  int AWIDTH = 16,
  localparam int VLW    = $clog2(VLEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EWIDTH*VLEN-1:0] src_data,
  input  logic [AWIDTH-1:0]      base_addr,
  input  logic [AWIDTH-1:0]      stride,
  input  logic [VLW-1:0]         vl,
`ifdef VSTORE_MASK_EN
  input  logic [VLEN-1:0]        mask,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AWIDTH-1:0]      mem_addr,
  output logic [EWIDTH-1:0]      mem_wdata,
  output logic                   mem_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [EWIDTH*VLEN-1:0] r_data;
  logic [AWIDTH-1:0]      r_addr;
  logic [AWIDTH-1:0]      r_stride;
  logic [VLW-1:0]         r_idx;
  logic [VLW-1:0]         r_evl;
  logic [VLW-1:0]         r_last_idx;
  logic [VLW-1:0]         w_evl;
  logic [VLW-1:0]         w_last_idx;
  logic                   w_accept;
  logic                   w_beat_en;
  logic                   w_adv;

  assign w_evl    = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
  assign w_accept = (r_state == S_IDLE) && start;

`ifdef VSTORE_MASK_EN
  logic [VLEN-1:0] r_mask;

  // Element 0 of the shifted mask always describes the element currently at r_idx.
  assign w_beat_en = r_mask[0];

  always_comb begin
    w_last_idx = '0;
    for (int k = 0; k < VLEN; k++) begin
      if (mask[k] && (VLW'(k) < w_evl)) w_last_idx = VLW'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (w_accept) begin
      r_mask <= mask;
    end else if (w_adv) begin
      r_mask <= r_mask >> 1;
    end
  end
`else
  assign w_beat_en  = 1'b1;
  assign w_last_idx = w_evl - VLW'(1);
`endif

  assign w_adv     = (r_state == S_SEND) && (!w_beat_en || mem_ready);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign mem_valid = (r_state == S_SEND) && w_beat_en;
  assign mem_last  = mem_valid && (r_idx == r_last_idx);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_data[EWIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (w_evl == '0) ? S_FIN : S_SEND;
      S_SEND: if (w_adv && (r_idx == r_evl - VLW'(1))) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The vector is shifted down one element per slot so the beat data is always the low element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_addr     <= '0;
      r_stride   <= '0;
      r_idx      <= '0;
      r_evl      <= '0;
      r_last_idx <= '0;
    end else if (w_accept) begin
      r_data     <= src_data;
      r_addr     <= base_addr;
      r_stride   <= stride;
      r_idx      <= '0;
      r_evl      <= w_evl;
      r_last_idx <= w_last_idx;
    end else if (w_adv) begin
      r_data     <= r_data >> EWIDTH;
      r_addr     <= r_addr + r_stride;
      r_idx      <= r_idx + VLW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_store_unit.sv
// tb_vector_store_unit: scoreboard bench for vector_store_unit (rev 1.0).
`default_nettype none

module tb_vector_store_unit;

  localparam int VLEN   = 8;
  localparam int EWIDTH = 32;
  localparam int AWIDTH = 16;
  localparam int VLW    = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [EWIDTH*VLEN-1:0] src_data = '0;
  logic [AWIDTH-1:0]      base_addr = '0;
  logic [AWIDTH-1:0]      stride = '0;
  logic [VLW-1:0]         vl = '0;
  logic [VLEN-1:0]        mask = '1;
  logic                   mem_ready = 1'b1;
  logic                   busy, done, mem_valid, mem_last;
  logic [AWIDTH-1:0]      mem_addr;
  logic [EWIDTH-1:0]      mem_wdata;

  vector_store_unit #(.VLEN(VLEN), .EWIDTH(EWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_data  (src_data),
    .base_addr (base_addr),
    .stride    (stride),
    .vl        (vl),
`ifdef VSTORE_MASK_EN
    .mask      (mask),
`endif
    .busy      (busy),
    .done      (done),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_last  (mem_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [EWIDTH-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic bit elem_en(input logic [VLEN-1:0] m, input int k);
`ifdef VSTORE_MASK_EN
    return m[k];
`else
    return (m[k] | 1'b1);
`endif
  endfunction

  task automatic run_store(input logic [AWIDTH-1:0] b, input logic [AWIDTH-1:0] s,
                           input logic [VLW-1:0] v, input logic [VLEN-1:0] m,
                           input logic [31:0] stall, input bit pattern, input int exp_done,
                           input int pulse_cyc, input int abort_cyc);
    int                evl;
    int                last_k;
    bit                seen_done;
    bit                prev_stall;
    beat_t             prev;
    beat_t             bt;
    logic [AWIDTH-1:0] a;
    @(posedge clk); #1;
    for (int k = 0; k < VLEN; k++)
      src_data[k*EWIDTH +: EWIDTH] = pattern ? EWIDTH'((k + 1) * 32'h11) : $urandom;
    base_addr = b; stride = s; vl = v; mask = m; start = 1'b1; mem_ready = 1'b1;
    evl = (int'(v) > VLEN) ? VLEN : int'(v);
    last_k = -1;
    for (int k = 0; k < evl; k++) if (elem_en(m, k)) last_k = k;
    exp_q.delete();
    a = b;
    for (int k = 0; k < evl; k++) begin
      if (elem_en(m, k)) exp_q.push_back({a, src_data[k*EWIDTH +: EWIDTH], (k == last_k)});
      a = a + s;
    end
    @(posedge clk); #1;
    // Inputs are scrambled after the accept edge; the DUT must have latched them.
    for (int k = 0; k < VLEN; k++) src_data[k*EWIDTH +: EWIDTH] = $urandom;
    base_addr = AWIDTH'($urandom); stride = AWIDTH'($urandom); vl = VLW'($urandom); mask = VLEN'($urandom);
    seen_done = 1'b0; prev_stall = 1'b0; prev = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      mem_ready = (c < 32) ? !stall[c] : 1'b1;
      start     = (c == pulse_cyc);
      @(negedge clk);
      if (prev_stall) begin
        check("hold_valid", 64'(mem_valid), 64'd1);
        check("hold_beat", 64'({mem_addr, mem_wdata, mem_last}), 64'(prev));
      end
      prev_stall = mem_valid && !mem_ready;
      prev = {mem_addr, mem_wdata, mem_last};
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          bt = exp_q.pop_front();
          check("beat_addr", 64'(mem_addr), 64'(bt.addr));
          check("beat_data", 64'(mem_wdata), 64'(bt.data));
          check("beat_last", 64'(mem_last), 64'(bt.last));
        end
      end
      if (c == abort_cyc) begin
        #1 rst = 1'b1;
        #1;
        check("abort_valid", 64'(mem_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", 64'(mem_addr), 64'd0);
        #1 rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (done) begin
        if (exp_done >= 0) check("done_cycle", 64'(c), 64'(exp_done));
        check("busy_at_done", 64'(busy), 64'd1);
        check("beats_missing", 64'(exp_q.size()), 64'd0);
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
      check("done_after", 64'(done), 64'd0);
      check("valid_after", 64'(mem_valid), 64'd0);
    end
    start = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_last", 64'(mem_last), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_store(16'h0100, 16'd4, 4'd8,  '1, 32'h0,          1'b1, 9, 0, 0);   // basic
    run_store(16'h0040, 16'd12, 4'd3, '1, 32'b1100,       1'b0, 6, 0, 0);   // backpressure on beat 1
    run_store(16'h0500, 16'd4, 4'd0,  '1, 32'h0,          1'b0, 1, 0, 0);   // vl=0
    run_store(16'h0600, 16'd4, 4'd12, '1, 32'h0,          1'b0, 9, 0, 0);   // vl clamped
    run_store(16'hFFF8, 16'd8, 4'd3,  '1, 32'h0,          1'b0, 4, 2, 0);   // wrap + ignored start
    run_store(16'h0040, 16'd0, 4'd4,  '1, 32'h0,          1'b0, 5, 0, 0);   // stride 0
    run_store(16'h0200, 16'd4, 4'd8,  '1, 32'h0,          1'b0, -1, 0, 2);  // reset mid-store
    run_store(16'h0300, 16'd4, 4'd8,  '1, 32'h0,          1'b0, 9, 0, 0);   // fresh store after reset
    run_store(16'h1234, 16'd20, 4'd6, '1, $urandom & 32'h0FFE, 1'b0, -1, 0, 0);
`ifdef VSTORE_MASK_EN
    run_store(16'h0100, 16'd4, 4'd8,  8'b1010_0101, 32'h0, 1'b1, 9, 0, 0);
    run_store(16'h0100, 16'd4, 4'd5,  8'h00,        32'h0, 1'b0, 6, 0, 0);
    run_store(16'h0100, 16'd4, 4'd6,  8'b1011_0110, 32'b10100, 1'b0, -1, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_store_unit.md
Name: vector_store_unit

Overview:
- Downstream of the vector ALU.
- Accepts one full VLEN-element result vector and serialises it, one element per beat, onto a valid/ready memory write port.
- Supports a programmable base address and byte stride.
- Reports busy while draining and pulses done at completion, so the issue logic can release the destination and start the next instruction.

Parameters:
VLEN, 8, elements per vector
EWIDTH, 32, element width in bits
AWIDTH, 16, memory byte-address width
VLW, $clog2(VLEN+1) (localparam, 4 at default), width of vl port

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous active-high
start  input  1  request store; sampled only when busy=0
src_data  input  EWIDTH*VLEN  vector to store; element k at [k*EWIDTH +: EWIDTH]
base_addr  input  AWIDTH  byte address of element 0
stride  input  AWIDTH  byte distance between consecutive elements
vl  input  VLW  number of elements to store (0..VLEN)
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle completion pulse
mem_valid  output  1  write beat valid
mem_ready  input  1  memory accepts beat when valid&ready
mem_addr  output  AWIDTH  beat address
mem_wdata  output  EWIDTH  beat data
mem_last  output  1  marks final beat of the store

Behaviour:
- Reset (async, any time, including mid-store): state=IDLE; busy, done, mem_valid, mem_last=0; mem_addr, mem_wdata, idx=0. Partial stores are abandoned, with no resume.
- FSM states: IDLE, SEND, FIN.
- IDLE: on start=1, latch src_data, base_addr, stride, and eff_vl=min(vl,VLEN); idx=0, cur_addr=base_addr. Next state is SEND if eff_vl>0, else FIN.
- SEND: mem_valid=1; mem_addr=cur_addr; mem_wdata=element idx; mem_last=(idx==eff_vl-1). All outputs come from registers.
- On valid&ready: idx+=1; cur_addr+=stride (mod 2^AWIDTH, wrap silently). After the last beat, go to FIN.
- Backpressure: while mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_last hold stable. mem_valid never drops until the beat is accepted.
- FIN: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- Latency: with mem_ready tied high, start accepted at edge 0 gives beats on cycles 1..eff_vl and done on cycle eff_vl+1. For vl=0, done on cycle 1 with no beats.
- start while busy=1: ignored, not queued.
- Inputs are latched at accept: src_data, base_addr, stride and vl may change freely after the accept edge.
- stride=0: every beat goes to base_addr (legal).

Optional Feature:
- Macro VSTORE_MASK_EN adds input mask[VLEN-1:0], latched with start.
- With the macro, a masked-off element (mask[k]=0) spends one SEND cycle with mem_valid=0, and cur_addr still advances by stride.
- With the macro, mem_last goes on the highest-index enabled element below eff_vl, precomputed at accept.
- With the macro, all-zero mask: no beats, done after eff_vl+1 cycles.
- Without the macro: no mask port, all elements are stored.

Test Plan:
- Basic store: vl=8, base=0x100, stride=4, mem_ready=1, elements 0x11..0x88 -> addrs 0x100,0x104..0x11C; data in order; mem_last on 8th beat; done on cycle 9; busy low on cycle 10.
- Backpressure: vl=3, mem_ready low 2 cycles at beat 1 -> beat 1 addr/data held 3 cycles; exactly 3 accepted beats; done 1 cycle after 3rd accept.
- Edge lengths:
  - vl=0 -> no mem_valid; done on cycle 1.
  - vl=12 -> clamped to 8 beats.
- Wrap and ignored start: base=0xFFF8, stride=8, vl=3 -> addrs 0xFFF8, 0x0000, 0x0008; start pulsed mid-store -> no second store.
- Reset mid-store: assert rst during beat 2 of 8 -> mem_valid/busy drop asynchronously the same cycle; a fresh start afterwards stores all 8 beats from the new base.
- Mask (VSTORE_MASK_EN): mask=8'b1010_0101, vl=8 -> beats only at idx 0, 2, 5, 7; mem_last at idx 7; done on cycle 9.
